// File: rtl/pipe_field_if.sv
// Control/status bundle between the game FSM, the renderer and pipe_field.
// master: game side (drives Start/Lost/Speed, consumes pipe state).
// slave : pipe_field (consumes controls, drives packed pipe buses).
interface pipe_field_if #(
  parameter int NUM_PIPES = 2,
  parameter int XW        = 10
);
  logic                      Start;
  logic                      Lost;
  logic [1:0]                Speed;
  logic [NUM_PIPES*XW-1:0]   PipeX;
  logic [NUM_PIPES*XW-1:0]   PipeY;
  logic [NUM_PIPES-1:0]      PipeActive;
  logic                      ScorePulse;
  logic [1:0]                State;

  modport master (
    output Start, Lost, Speed,
    input  PipeX, PipeY, PipeActive, ScorePulse, State
  );

  modport slave (
    input  Start, Lost, Speed,
    output PipeX, PipeY, PipeActive, ScorePulse, State
  );
endinterface

// File: rtl/pipe_field.sv
// Scrolling pipe obstacle generator for the Flappy Bird VGA game.
// Ports: Clk, Reset (async, active-low); bus (pipe_field_if.slave):
//   Start/Lost/Speed in; PipeX/PipeY (packed, pipe k at [k*XW +: XW]),
//   PipeActive, ScorePulse, State (00 idle, 01 run, 10 lost) out.
module pipe_field #(
  parameter int         NUM_PIPES = 2,
  parameter int         XW        = 10,
  parameter int         SCREEN_W  = 800,
  parameter int         SPACING   = 288,
  parameter int         PIPE_W    = 60,
  parameter int         STEP_DIV  = 500000,
  parameter int         BIRD_X    = 200,
  parameter int         GAP_MIN   = 50,
  parameter logic [7:0] GAP_MASK  = 8'hFF,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic          Clk,
  input logic          Reset,
  pipe_field_if.slave  bus
);

  localparam int unsigned DW = $clog2(STEP_DIV);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_LOST = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     div_q, div_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [XW-1:0]     x_q [NUM_PIPES];
  logic [XW-1:0]     x_d [NUM_PIPES];
  logic [XW-1:0]     y_q [NUM_PIPES];
  logic [XW-1:0]     y_d [NUM_PIPES];
  logic [NUM_PIPES-1:0] act_q, act_d;
  logic              score_q, score_d;

  logic              tick;
  logic [XW-1:0]     gap;
  int                step;
  int                pos_old [NUM_PIPES];
  int                pos_new [NUM_PIPES];

  // Next-state logic for FSM, divider, LFSR and pipe channels.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    x_d     = x_q;
    y_d     = y_q;
    act_d   = act_q;
    score_d = 1'b0;
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    tick    = (div_q == DW'(STEP_DIV - 1));
    gap     = XW'(GAP_MIN) + XW'(lfsr_q[7:0] & GAP_MASK);
    step    = int'(bus.Speed) + 1;

    // X codes above SCREEN_W are a pipe hanging off the left edge (negative X).
    for (int k = 0; k < NUM_PIPES; k++) begin
      pos_old[k] = (int'(x_q[k]) > SCREEN_W) ? int'(x_q[k]) - (1 << XW) : int'(x_q[k]);
      pos_new[k] = pos_old[k];
    end

    unique case (state_q)
      ST_IDLE: begin
        div_d = '0;
        if (bus.Start && !bus.Lost) begin
          state_d  = ST_RUN;
          act_d[0] = 1'b1;
          x_d[0]   = XW'(SCREEN_W);
          y_d[0]   = gap;
        end
      end

      ST_RUN: begin
        if (bus.Lost) begin
          state_d = ST_LOST;
        end else begin
          div_d = tick ? '0 : div_q + DW'(1);
          if (tick) begin
            for (int k = 0; k < NUM_PIPES; k++) begin
              if (act_q[k]) begin
                if (pos_old[k] - step + PIPE_W <= 0) begin
                  pos_new[k] = SCREEN_W;
                  y_d[k]     = gap;
                end else begin
                  pos_new[k] = pos_old[k] - step;
                end
                x_d[k] = XW'(pos_new[k]);
                if ((pos_old[k] + PIPE_W > BIRD_X) && (pos_new[k] + PIPE_W <= BIRD_X))
                  score_d = 1'b1;
              end
            end
            // Stagger: a channel launches once its predecessor has moved SPACING in.
            for (int k = 1; k < NUM_PIPES; k++) begin
              if (!act_q[k] && act_q[k-1] && (pos_new[k-1] <= SCREEN_W - SPACING)) begin
                act_d[k] = 1'b1;
                x_d[k]   = XW'(SCREEN_W);
                y_d[k]   = gap;
              end
            end
          end
        end
      end

      ST_LOST: begin
        if (bus.Start) begin
          state_d = ST_IDLE;
          div_d   = '0;
          act_d   = '0;
          for (int k = 0; k < NUM_PIPES; k++) begin
            x_d[k] = XW'(SCREEN_W);
            y_d[k] = XW'(GAP_MIN);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      act_q   <= '0;
      score_q <= 1'b0;
      for (int k = 0; k < NUM_PIPES; k++) begin
        x_q[k] <= XW'(SCREEN_W);
        y_q[k] <= XW'(GAP_MIN);
      end
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      lfsr_q  <= lfsr_d;
      act_q   <= act_d;
      score_q <= score_d;
      for (int k = 0; k < NUM_PIPES; k++) begin
        x_q[k] <= x_d[k];
        y_q[k] <= y_d[k];
      end
    end
  end

  // Pack channel registers onto the output buses.
  logic [NUM_PIPES*XW-1:0] px_c, py_c;
  always_comb begin
    px_c = '0;
    py_c = '0;
    for (int k = 0; k < NUM_PIPES; k++) begin
      px_c[k*XW +: XW] = x_q[k];
      py_c[k*XW +: XW] = y_q[k];
    end
  end

  assign bus.PipeX      = px_c;
  assign bus.PipeY      = py_c;
  assign bus.PipeActive = act_q;
  assign bus.ScorePulse = score_q;
  assign bus.State      = state_q;

endmodule
